// File: rtl/cic_pkg.sv
// ------------------------------------------------------------------
// cic_pkg : shared constants and width helper for the CIC decimator.
// Revision : 1.0
// ------------------------------------------------------------------
`default_nettype none

package cic_pkg;

  localparam int c_decim_def     = 25;
  localparam int c_order_def     = 3;
  localparam int c_out_w_def     = 20;
  localparam int c_out_shift_def = 5;

  // Bitstream symbol as a 2-bit two's complement value.
  localparam logic [1:0] c_x_pos = 2'b01;
  localparam logic [1:0] c_x_neg = 2'b11;

  // Growth of ORDER integrators over DECIM samples plus the 2-bit input.
  function automatic int acc_width(input int decim, input int order);
    return 2 + order * $clog2(decim);
  endfunction

endpackage

`default_nettype wire

// File: rtl/cic_comb_stage.sv
// ------------------------------------------------------------------
// cic_comb_stage : one registered differentiator with a valid token.
// Revision : 1.0
// ------------------------------------------------------------------
`default_nettype none

module cic_comb_stage #(
  parameter int W = 17
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         valid_i,
  input  logic [W-1:0] data_i,
  output logic         valid_o,
  output logic [W-1:0] data_o
);

  logic [W-1:0] dly_q, dly_d;
  logic [W-1:0] data_q, data_d;
  logic         valid_q;

  always_comb begin
    dly_d  = dly_q;
    data_d = data_q;
    if (valid_i) begin
      data_d = data_i - dly_q;
      dly_d  = data_i;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      dly_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      dly_q   <= dly_d;
      data_q  <= data_d;
      valid_q <= valid_i;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;

endmodule

`default_nettype wire

// File: rtl/cic_decim.sv
// ------------------------------------------------------------------
// cic_decim : CIC decimator turning a 1-bit delta-sigma stream into PCM.
// Revision : 1.0
// ------------------------------------------------------------------
`default_nettype none

module cic_decim
  import cic_pkg::*;
#(
  parameter int DECIM     = c_decim_def,
  parameter int ORDER     = c_order_def,
  parameter int OUT_W     = c_out_w_def,
  parameter int OUT_SHIFT = c_out_shift_def
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             bit_in,
  input  logic             bit_en,
  output logic [OUT_W-1:0] sample_out,
  output logic             sample_valid
);

  localparam int c_acc_w = acc_width(DECIM, ORDER);
  localparam int c_ph_w  = $clog2(DECIM);
  localparam int c_ext_w = (OUT_W > c_acc_w) ? OUT_W : c_acc_w;

  logic [1:0]                     w_x;
  logic                           w_tick;
  logic [c_ph_w-1:0]              phase_q, phase_d;
  logic [ORDER-1:0][c_acc_w-1:0]  integ_q, integ_d;
  logic [c_acc_w-1:0]             dec_q, dec_d;
  logic                           dec_valid_q;

  assign w_x    = bit_in ? c_x_pos : c_x_neg;
  assign w_tick = bit_en && (phase_q == c_ph_w'(DECIM - 1));

  // Every integrator reads its predecessor's pre-update value; wrap is intended.
  always_comb begin
    integ_d = integ_q;
    if (bit_en) begin
      integ_d[0] = integ_q[0] + {{(c_acc_w - 2){w_x[1]}}, w_x};
      for (int k = 1; k < ORDER; k++) begin
        integ_d[k] = integ_q[k] + integ_q[k-1];
      end
    end
  end

  always_comb begin
    phase_d = phase_q;
    if (bit_en) begin
      phase_d = w_tick ? '0 : phase_q + 1'b1;
    end
  end

  assign dec_d = w_tick ? integ_q[ORDER-1] : dec_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      integ_q     <= '0;
      phase_q     <= '0;
      dec_q       <= '0;
      dec_valid_q <= 1'b0;
    end else begin
      integ_q     <= integ_d;
      phase_q     <= phase_d;
      dec_q       <= dec_d;
      dec_valid_q <= w_tick;
    end
  end

  logic [c_acc_w-1:0] comb_data  [ORDER+1];
  logic               comb_valid [ORDER+1];

  assign comb_data[0]  = dec_q;
  assign comb_valid[0] = dec_valid_q;

  // Comb chain runs at full clock rate so an in-flight token ignores bit_en.
  generate
    for (genvar k = 0; k < ORDER; k++) begin : g_comb
      cic_comb_stage #(
        .W(c_acc_w)
      ) u_stage (
        .clock   (clock),
        .reset   (reset),
        .valid_i (comb_valid[k]),
        .data_i  (comb_data[k]),
        .valid_o (comb_valid[k+1]),
        .data_o  (comb_data[k+1])
      );
    end
  endgenerate

  logic signed [c_ext_w-1:0] w_wide;
  logic signed [c_ext_w-1:0] w_shifted;

  assign w_wide       = c_ext_w'($signed(comb_data[ORDER]));
  assign w_shifted    = w_wide <<< OUT_SHIFT;
  assign sample_out   = w_shifted[OUT_W-1:0];
  assign sample_valid = comb_valid[ORDER];

endmodule

`default_nettype wire

// File: tb/tb_cic_decim.sv
// ------------------------------------------------------------------
// tb_cic_decim : scoreboard bench for the CIC decimator.
// Revision : 1.0
// ------------------------------------------------------------------
`default_nettype none

module tb_cic_decim;

  localparam int D = 25;

  logic        clock;
  logic        reset;
  logic        bit_in;
  logic        bit_en;
  logic [19:0] sample_out;
  logic        sample_valid;

  cic_decim dut (
    .clock        (clock),
    .reset        (reset),
    .bit_in       (bit_in),
    .bit_en       (bit_en),
    .sample_out   (sample_out),
    .sample_valid (sample_valid)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    int          due;
    logic [19:0] val;
    bit          chk;
  } exp_t;

  exp_t        sb[$];
  int          valid_cycles[$];
  int          total = 0;
  int          bad = 0;
  int          cyc = 0;
  int          phase = 0;
  int          pulses = 0;
  logic [19:0] settled = '0;

  // Drive one cycle; expected pulses are queued at the tick and retired when seen.
  task automatic step(input bit rst, input bit b, input bit en);
    exp_t e;
    reset  = rst;
    bit_in = b;
    bit_en = en;
    if (rst) begin
      phase  = 0;
      pulses = 0;
      sb.delete();
    end else if (en) begin
      if (phase == D - 1) begin
        phase  = 0;
        pulses++;
        e.due = cyc + 4;
        e.val = settled;
        e.chk = (pulses >= 4);
        sb.push_back(e);
      end else begin
        phase++;
      end
    end
    @(posedge clock);
    #1;
    cyc++;
    if (sample_valid === 1'b1) begin
      valid_cycles.push_back(cyc);
      total++;
      if (sb.size() == 0) begin
        bad++;
        $display("FAIL spurious_valid: sample_valid=1 at cycle %0d, required no pulse", cyc);
      end else begin
        e = sb.pop_front();
        if (cyc != e.due) begin
          bad++;
          $display("FAIL pulse_time: pulse at cycle %0d, required cycle %0d", cyc, e.due);
        end
        if (e.chk) begin
          total++;
          if (sample_out !== e.val) begin
            bad++;
            $display("FAIL sample_value: got %0d, required %0d",
                     $signed(sample_out), $signed(e.val));
          end
        end
      end
    end else if (sb.size() != 0 && sb[0].due <= cyc) begin
      total++;
      bad++;
      $display("FAIL missing_pulse: no sample_valid at cycle %0d, required pulse due %0d",
               cyc, sb[0].due);
      e = sb.pop_front();
    end
  endtask

  task automatic do_reset();
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    valid_cycles.delete();
  endtask

  task automatic drain();
    for (int i = 0; i < 6; i++) step(1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_reset();
    do_reset();
    total++;
    if (sample_valid !== 1'b0) begin
      bad++;
      $display("FAIL reset_valid: got %b, required 0", sample_valid);
    end
    total++;
    if (sample_out !== 20'd0) begin
      bad++;
      $display("FAIL reset_out: got %h, required 00000", sample_out);
    end
  endtask

  task automatic run_const(input bit b, input logic [19:0] val, input int n, input string name);
    settled = val;
    do_reset();
    for (int i = 0; i < n; i++) step(1'b0, b, 1'b1);
    drain();
    total++;
    if (valid_cycles.size() != n / D) begin
      bad++;
      $display("FAIL %s_count: got %0d pulses, required %0d", name, valid_cycles.size(), n / D);
    end
  endtask

  task automatic test_all_ones();
    run_const(1'b1, 20'h7A120, 10 * D, "ones");
  endtask

  task automatic test_all_zeros();
    run_const(1'b0, 20'h85EE0, 10 * D, "zeros");
  endtask

  task automatic test_wrap();
    run_const(1'b1, 20'h7A120, 2000 * D, "wrap");
  endtask

  task automatic test_pattern();
    settled = 20'd20000;
    do_reset();
    for (int p = 0; p < 10; p++) begin
      for (int i = 0; i < D; i++) step(1'b0, (i < 13), 1'b1);
    end
    drain();
    total++;
    if (valid_cycles.size() != 10) begin
      bad++;
      $display("FAIL pattern_count: got %0d pulses, required 10", valid_cycles.size());
    end
  endtask

  task automatic test_stall();
    int n35;
    int nodd;
    int g;
    settled = 20'h7A120;
    do_reset();
    for (int i = 0; i < 8 * D; i++) step(1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 10; i++) step(1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 3 * D; i++) step(1'b0, 1'b1, 1'b1);
    drain();
    n35  = 0;
    nodd = 0;
    for (int i = 1; i < valid_cycles.size(); i++) begin
      g = valid_cycles[i] - valid_cycles[i-1];
      if (g == 35) n35++;
      else if (g != D) nodd++;
    end
    total++;
    if (valid_cycles.size() != 11) begin
      bad++;
      $display("FAIL stall_count: got %0d pulses, required 11", valid_cycles.size());
    end
    total++;
    if (n35 != 1) begin
      bad++;
      $display("FAIL stall_gap35: got %0d stretched gaps, required 1", n35);
    end
    total++;
    if (nodd != 0) begin
      bad++;
      $display("FAIL stall_gap_other: got %0d gaps not 25/35, required 0", nodd);
    end
  endtask

  task automatic test_reset_mid();
    settled = 20'h7A120;
    do_reset();
    for (int i = 0; i < 5 * D; i++) step(1'b0, 1'b1, 1'b1);
    step(1'b0, 1'b1, 1'b1);
    step(1'b1, 1'b1, 1'b1);
    total++;
    if (sample_out !== 20'd0) begin
      bad++;
      $display("FAIL midreset_out: got %h, required 00000", sample_out);
    end
    total++;
    if (sample_valid !== 1'b0) begin
      bad++;
      $display("FAIL midreset_valid: got %b, required 0", sample_valid);
    end
    valid_cycles.delete();
    for (int i = 0; i < 6 * D; i++) step(1'b0, 1'b1, 1'b1);
    drain();
    total++;
    if (valid_cycles.size() != 6) begin
      bad++;
      $display("FAIL restart_count: got %0d pulses, required 6", valid_cycles.size());
    end
  endtask

  initial begin
    reset  = 1'b1;
    bit_in = 1'b0;
    bit_en = 1'b0;
    test_reset();
    test_all_ones();
    test_all_zeros();
    test_pattern();
    test_stall();
    test_reset_mid();
    test_wrap();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
